// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch block.
//   DEF_ADDR_W          - byte address width of the instruction memory
//   DEF_RESET_PC        - default fetch PC after reset (4-byte aligned)
//   DEF_BYTES_PER_INSTR - bytes per instruction word
//   RD_DEPTH            - edges from address issue to byte capture
//   fetch_state_t       - fetch FSM states
package fetch_pkg;
  localparam int              DEF_ADDR_W          = 14;
  localparam logic [13:0]     DEF_RESET_PC        = 14'd4096;
  localparam int              DEF_BYTES_PER_INSTR = 4;
  // Address is sampled by the memory one edge after issue, and the byte is
  // captured one edge after that.
  localparam int              RD_DEPTH            = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_byte_assembler.sv
// fetch_byte_assembler: tracks bytes in flight through the synchronous
// memory read port and places each returned byte into its lane of the
// assembled little-endian word.
// Ports:
//   clk, reset          - clock, async active-high reset
//   flush               - drop everything in flight and clear the word
//   issue_valid/lane    - an address for byte 'lane' was issued this edge
//   byte_in             - byte returned by the memory
//   word                - assembled word, lane k in bits [8k+7:8k]
//   last_capture        - the top lane is being captured at this edge
module fetch_byte_assembler
  import fetch_pkg::*;
#(
  parameter int LANES  = DEF_BYTES_PER_INSTR,
  parameter int LANE_W = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [LANE_W-1:0]   issue_lane,
  input  logic [7:0]          byte_in,
  output logic [8*LANES-1:0]  word,
  output logic                last_capture
);
  logic [RD_DEPTH-1:0]             vld_pipe;
  logic [RD_DEPTH-1:0][LANE_W-1:0] lane_pipe;
  logic [LANES-1:0][7:0]           word_q;

  assign word         = word_q;
  assign last_capture = vld_pipe[RD_DEPTH-1] &&
                        (lane_pipe[RD_DEPTH-1] == LANE_W'(LANES-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      lane_pipe <= '0;
      word_q    <= '0;
    end else begin
      // Stage 0 takes the new issue even on a flush: a redirect issues the
      // first byte of the new target on the same edge it flushes.
      vld_pipe[0]  <= issue_valid;
      lane_pipe[0] <= issue_lane;
      for (int i = 1; i < RD_DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1] & ~flush;
        lane_pipe[i] <= lane_pipe[i-1];
      end
      if (flush)
        word_q <= '0;
      else if (vld_pipe[RD_DEPTH-1])
        word_q[lane_pipe[RD_DEPTH-1]] <= byte_in;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the fetch PC, issues four byte addresses per word
// to the 1-cycle synchronous instruction memory, and hands the assembled
// word to the decoder over valid/ready. No prefetch overlap: one word per
// 6 cycles with ready held high.
// Ports:
//   clk, reset                 - clock, async active-high reset
//   fetch_enable               - permits a new word fetch to start
//   mem_address/mem_read_data  - memory read port (address registered)
//   instr/instr_pc/instr_valid - word, its byte address, valid
//   instr_ready                - decoder accepts the word
//   redirect_valid/redirect_pc - load a new (word-aligned) fetch PC
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W          = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(DEF_RESET_PC),
  parameter int                BYTES_PER_INSTR = DEF_BYTES_PER_INSTR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_enable,
  output logic [ADDR_W-1:0]            mem_address,
  input  logic [7:0]                   mem_read_data,
  output logic [8*BYTES_PER_INSTR-1:0] instr,
  output logic [ADDR_W-1:0]            instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc
);
  localparam int LANE_W = $clog2(BYTES_PER_INSTR);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, addr_next, ipc_next, redirect_aligned;
  logic [LANE_W-1:0] cnt, cnt_next, issue_lane;
  logic              issue_valid, flush, valid_next, last_capture;
  logic              unused_redirect_lsbs;

  assign redirect_aligned     = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    addr_next   = mem_address;
    cnt_next    = cnt;
    issue_valid = 1'b0;
    issue_lane  = cnt;
    flush       = 1'b0;
    valid_next  = instr_valid;
    ipc_next    = instr_pc;

    if (redirect_valid) begin
      // Redirect beats everything, including a same-edge handshake.
      flush      = 1'b1;
      valid_next = 1'b0;
      pc_next    = redirect_aligned;
      state_next = IDLE;
      if (fetch_enable) begin
        state_next  = ISSUE;
        addr_next   = redirect_aligned;
        issue_valid = 1'b1;
        issue_lane  = '0;
        cnt_next    = LANE_W'(1);
      end
    end else begin
      unique case (state)
        IDLE: if (fetch_enable) begin
          state_next  = ISSUE;
          addr_next   = pc;
          issue_valid = 1'b1;
          issue_lane  = '0;
          cnt_next    = LANE_W'(1);
        end
        ISSUE: begin
          addr_next   = pc + ADDR_W'(cnt);
          issue_valid = 1'b1;
          issue_lane  = cnt;
          cnt_next    = cnt + LANE_W'(1);
          if (cnt == LANE_W'(BYTES_PER_INSTR-1)) state_next = DRAIN;
        end
        DRAIN: if (last_capture) begin
          valid_next = 1'b1;
          ipc_next   = pc;
          state_next = HOLD;
        end
        HOLD: if (instr_ready) begin
          valid_next = 1'b0;
          pc_next    = pc + ADDR_W'(BYTES_PER_INSTR);
          state_next = IDLE;
          if (fetch_enable) begin
            state_next  = ISSUE;
            addr_next   = pc + ADDR_W'(BYTES_PER_INSTR);
            issue_valid = 1'b1;
            issue_lane  = '0;
            cnt_next    = LANE_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      mem_address <= RESET_PC;
      cnt         <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      mem_address <= addr_next;
      cnt         <= cnt_next;
      instr_valid <= valid_next;
      instr_pc    <= ipc_next;
    end
  end

  fetch_byte_assembler #(.LANES(BYTES_PER_INSTR), .LANE_W(LANE_W)) u_asm (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_lane   (issue_lane),
    .byte_in      (mem_read_data),
    .word         (instr),
    .last_capture (last_capture)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed + random stimulus against a timeline model
// of the fetch block (edges since fetch start, expected PC, expected word
// read straight from the memory image).
module tb_instruction_fetch;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_enable = 1'b0;
  logic          instr_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_read_data = 8'h00;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;

  logic [7:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  // model: ph 0=idle, 1=fetching (t edges since start), 2=word held
  int            ph, t;
  logic [AW-1:0] m_pc, m_addr, m_ipc;
  logic          m_valid;
  logic [31:0]   m_word;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .mem_address    (mem_address),
    .mem_read_data  (mem_read_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // 1-cycle synchronous read memory
  always @(posedge clk) mem_read_data <= mem[mem_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] a1, a2, a3;
    a1 = a + 14'd1; a2 = a + 14'd2; a3 = a + 14'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  task automatic model_reset();
    ph = 0; t = 0;
    m_pc = 14'd4096; m_addr = 14'd4096; m_ipc = '0;
    m_valid = 1'b0; m_word = '0;
  endtask

  task automatic model_start();
    ph = 1; t = 0; m_addr = m_pc;
  endtask

  task automatic model_edge();
    if (reset) model_reset();
    else if (redirect_valid) begin
      m_pc = {redirect_pc[AW-1:2], 2'b00};
      m_valid = 1'b0;
      if (fetch_enable) model_start(); else ph = 0;
    end else if (ph == 0) begin
      if (fetch_enable) model_start();
    end else if (ph == 1) begin
      t++;
      if (t <= 3) m_addr = m_pc + AW'(t);
      if (t == 5) begin
        m_valid = 1'b1; m_ipc = m_pc; m_word = mem_word(m_pc); ph = 2;
      end
    end else if (instr_ready) begin
      m_valid = 1'b0;
      m_pc = m_pc + 14'd4;
      if (fetch_enable) model_start(); else ph = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("mem_address", 32'(mem_address), 32'(m_addr));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    if (m_valid) chk("instr", instr, m_word);
  endtask

  task automatic wait_valid(input int bound);
    int k = 0;
    while (instr_valid !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    chk("valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'($urandom);
    {mem[4099], mem[4098], mem[4097], mem[4096]} = 32'h00000012;
    {mem[4103], mem[4102], mem[4101], mem[4100]} = 32'h12345678;
    {mem[8195], mem[8194], mem[8193], mem[8192]} = 32'h00000034;
    {mem[16383], mem[16382], mem[16381], mem[16380]} = 32'hDEADBEEF;
    {mem[3], mem[2], mem[1], mem[0]} = 32'h04030201;
    {mem[103], mem[102], mem[101], mem[100]} = 32'hCAFEF00D;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_address", 32'(mem_address), 32'd4096);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);

    // first two sequential words, ready high
    reset = 1'b0; fetch_enable = 1'b1; instr_ready = 1'b1;
    wait_valid(10);
    chk("w0_instr", instr, 32'h00000012);
    chk("w0_pc", 32'(instr_pc), 32'd4096);
    step();
    wait_valid(10);
    chk("w1_instr", instr, 32'h12345678);
    chk("w1_pc", 32'(instr_pc), 32'd4100);

    // decoder stalls 10 cycles
    instr_ready = 1'b0;
    repeat (10) step();
    chk("hold_mem_address", 32'(mem_address), 32'd4103);
    chk("hold_instr", instr, 32'h12345678);
    instr_ready = 1'b1;
    step();
    chk("after_hs_addr", 32'(mem_address), 32'd4104);

    // redirect while byte 2 of the 4104 word is issuing
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 14'd8195;
    step();
    redirect_valid = 1'b0;
    wait_valid(10);
    chk("redir_instr", instr, 32'h00000034);
    chk("redir_pc", 32'(instr_pc), 32'd8192);
    step();

    // wrap at the top of memory
    redirect_valid = 1'b1; redirect_pc = 14'd16382;
    step();
    redirect_valid = 1'b0;
    wait_valid(10);
    chk("wrap_instr", instr, 32'hDEADBEEF);
    chk("wrap_pc", 32'(instr_pc), 32'd16380);
    step();
    wait_valid(10);
    chk("wrap0_instr", instr, 32'h04030201);
    chk("wrap0_pc", 32'(instr_pc), 32'd0);

    // redirect on the handshake edge wins over pc+4
    redirect_valid = 1'b1; redirect_pc = 14'd100;
    step();
    redirect_valid = 1'b0;
    wait_valid(10);
    chk("redir_hs_instr", instr, 32'hCAFEF00D);
    chk("redir_hs_pc", 32'(instr_pc), 32'd100);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      fetch_enable   = ($urandom % 4) != 0;
      instr_ready    = ($urandom % 2) != 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = AW'($urandom_range(0, (1<<AW)-1));
      step();
    end

    // async reset while a word is held
    fetch_enable = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0;
    wait_valid(20);
    reset = 1'b1;
    #1;
    chk("hold_rst_valid", 32'(instr_valid), 32'd0);
    chk("hold_rst_instr", instr, 32'd0);
    chk("hold_rst_addr", 32'(mem_address), 32'd4096);
    model_reset();
    step();
    reset = 1'b0;

    // async reset in the middle of draining
    instr_ready = 1'b1;
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("drain_rst_valid", 32'(instr_valid), 32'd0);
    chk("drain_rst_addr", 32'(mem_address), 32'd4096);
    model_reset();
    step();
    reset = 1'b0;
    wait_valid(10);
    chk("restart_pc", 32'(instr_pc), 32'd4096);
    chk("restart_instr", instr, 32'h00000012);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
